// File: rtl/led_scan_pkg.sv
// led_scan_pkg -- definitions shared by the LED scan controller files.
//   scan_state_e : scan sequencer states (IDLE / BLANK / DRIVE)
//   MAX_N        : largest supported grid edge
package led_scan_pkg;

    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/led_scan_timer.sv
// led_scan_timer -- loadable down-counter for blank and dwell intervals.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load, load_val  : load count with load_val on this edge
//   count           : current count
//   count_next      : value count takes at the next edge
//   done            : count has reached zero
module led_scan_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          done
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign done       = (count_q == '0);

endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller -- double-buffered column scanner for an N x N LED
// array. A frame is accepted into a pending buffer with a valid/ready
// handshake and moved to the active buffer only at a scan boundary, so the
// array never shows a torn frame.
//
// Handshake: a frame transfers on every rising edge where frame_valid and
// frame_ready are both high; while frame_valid is high and frame_ready low
// the source holds frame_data stable. frame_ready is low whenever the
// pending buffer is full.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   frame_valid/data  : offered frame (N*N cell bits)
//   frame_ready       : pending buffer empty
//   ena               : column driver enable (registered)
//   x                 : column index (registered)
//   cells             : active frame
//   frame_done        : high during the final DRIVE clock of the last column
//   brightness        : 3-bit duty control, only when LED_SCAN_BRIGHTNESS_EN
//                       is defined
module led_scan_controller
    import led_scan_pkg::*;
#(
    parameter int N            = 5,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_valid,
    input  logic [N*N-1:0]       frame_data,
    output logic                 frame_ready,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [2:0]           brightness,
`endif
    output logic                 ena,
    output logic [$clog2(N):0]   x,
    output logic [N*N-1:0]       cells,
    output logic                 frame_done
);

    localparam int XW = $clog2(N) + 1;
    localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) + 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

    scan_state_e    state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic           ena_q, ena_d;
    logic           frame_done_q, frame_done_d;
    logic [N*N-1:0] pending_q, pending_d;
    logic           pending_full_q, pending_full_d;
    logic [N*N-1:0] active_q, active_d;

    logic           tmr_load;
    logic [CW-1:0]  tmr_load_val;
    logic [CW-1:0]  tmr_count;
    logic [CW-1:0]  tmr_count_next;
    logic           tmr_done;
    logic [CW-1:0]  elapsed_next;

    led_scan_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_val   (tmr_load_val),
        .count      (tmr_count),
        .count_next (tmr_count_next),
        .done       (tmr_done)
    );

    // Sequencer and buffer next-state.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;

        // Capture can only happen with the flag clear, and a swap only with
        // it set, so the two never fight over pending_full.
        if (frame_valid && !pending_full_q) begin
            pending_d      = frame_data;
            pending_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_full_q) begin
                    active_d       = pending_q;
                    pending_full_d = 1'b0;
                    x_d            = '0;
                    state_d        = BLANK;
                    tmr_load       = 1'b1;
                    tmr_load_val   = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (tmr_done) begin
                    state_d      = DRIVE;
                    tmr_load     = 1'b1;
                    tmr_load_val = DWELL_LOAD;
                end
            end
            DRIVE: begin
                if (tmr_done) begin
                    state_d      = BLANK;
                    tmr_load     = 1'b1;
                    tmr_load_val = BLANK_LOAD;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (pending_full_q) begin
                            active_d       = pending_q;
                            pending_full_d = 1'b0;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
            end
        endcase
    end

    // ena and frame_done are registered, so they are computed one clock
    // ahead from the timer's next count: elapsed_next is the DRIVE clock
    // index the next cycle will be.
    always_comb begin
        elapsed_next = DWELL_LOAD - tmr_count_next;
        frame_done_d = (state_d == DRIVE) && (x_d == X_LAST) && (tmr_count_next == '0);
`ifdef LED_SCAN_BRIGHTNESS_EN
        ena_d = (state_d == DRIVE) &&
                (int'(elapsed_next) < (((int'(brightness) + 1) * DWELL_CYCLES) / 8));
`else
        ena_d = (state_d == DRIVE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            x_q            <= '0;
            ena_q          <= 1'b0;
            frame_done_q   <= 1'b0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            ena_q          <= ena_d;
            frame_done_q   <= frame_done_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
        end
    end

    assign frame_ready = !pending_full_q;
    assign ena         = ena_q;
    assign x           = x_q;
    assign cells       = active_q;
    assign frame_done  = frame_done_q;

    // tmr_count is only observed through count_next/done.
    logic unused_count;
    assign unused_count = ^tmr_count;

endmodule
